rv_fetch_buffer: RTL and testbench
==================================

RV_FETCH_BUFFER -- requirements
Module: rv_fetch_buffer

Interface
REQ-001 Parameter DEPTH, default 2, entry count; legal values are powers of two from 2 to 8.
REQ-002 Parameters XLEN and ILEN SHALL come from rv_pkg and are not redeclared locally.
REQ-003 clk_i  input  1  clock; all state updates on the rising edge.
REQ-004 arstn_i  input  1  reset, asynchronous, active-low.
REQ-005 flush_i  input  1  pipeline redirect from the control unit; discards all buffered entries.
REQ-006 f_valid_i  input  1  fetch stage presents a valid fetched instruction.
REQ-007 f_pc_i  input  XLEN  PC of the fetched instruction.
REQ-008 f_pc_next_i  input  XLEN  PC+4 of the fetched instruction.
REQ-009 f_instr_i  input  ILEN  fetched instruction word.
REQ-010 f_ready_o  output  1  buffer can accept an entry this cycle.
REQ-011 d_valid_o  output  1  head entry is valid for decode.
REQ-012 d_pc_o  output  XLEN  head entry PC.
REQ-013 d_pc_next_o  output  XLEN  head entry PC+4.
REQ-014 d_instr_o  output  ILEN  head entry instruction word.
REQ-015 d_ready_i  input  1  decode consumes the head entry this cycle.
REQ-016 count_o  output  $clog2(DEPTH+1)  number of occupied entries.

Function
REQ-017 Storage is a circular FIFO with wr_ptr, rd_ptr ($clog2(DEPTH) bits, natural wrap from DEPTH-1 to 0) and an occupancy counter.
REQ-018 f_ready_o SHALL be ~full, where full means count == DEPTH, with no combinational dependence on d_ready_i.
REQ-019 push = f_valid_i & f_ready_o & ~flush_i: write {f_pc_i, f_pc_next_i, f_instr_i} at wr_ptr, then increment wr_ptr.
REQ-020 pop = d_valid_o & d_ready_i & ~flush_i: increment rd_ptr.
REQ-021 count next = count + push - pop, so a simultaneous push and pop leaves count unchanged.
REQ-022 d_valid_o SHALL be (count != 0); the d_* fields are driven from the entry at rd_ptr.
REQ-023 When empty, d_pc_o and d_pc_next_o SHALL be 0, and d_instr_o SHALL be rv_pkg::RV_NOP (32'h0000_0013).
REQ-024 There is no bypass: an entry pushed in cycle N is first visible on d_* in cycle N+1, giving minimum latency 1.
REQ-025 When full, f_ready_o is 0 even if d_ready_i=1; the pop in that cycle reopens f_ready_o in the next cycle.
REQ-026 f_valid_i while f_ready_o=0 SHALL be ignored; the fetch stage is responsible for holding or refetching.
REQ-027 flush_i=1 in cycle N: any push or pop in cycle N is suppressed, and in cycle N+1 count=0, wr_ptr=rd_ptr=0 and d_valid_o=0.
REQ-028 flush_i has priority over push, pop and full/empty conditions.
REQ-029 Stored entries SHALL hold their values unchanged while d_ready_i=0.
REQ-030 The push-on-full and pop-on-empty conditions cannot occur by construction; an assertion SHALL flag them in simulation.

Reset
REQ-031 On arstn_i low, count, wr_ptr and rd_ptr clear to 0 immediately, independent of clk_i.
REQ-032 Reset values: d_valid_o=0, f_ready_o=1, count_o=0, d_pc_o=0, d_pc_next_o=0, d_instr_o=RV_NOP.
REQ-033 Entry storage need not be reset, because REQ-023 masks it while the buffer is empty.
REQ-034 Reset asserted mid-operation discards all entries; the first push after release behaves as on an empty buffer.

Structure
REQ-035 rv_pkg holds the constant RV_NOP and the typedef fetch_pkt_t {pc, pc_next, instr}; storage is an array of fetch_pkt_t.
REQ-036 No sub-module is used; pointers, counter and storage are implemented inline.

Verification
REQ-037 After reset, push pc=0x0/instr=0x00500093, then pc=0x4/instr=0x00A00113, with d_ready_i=1 -> d_* shows pc=0x0 the cycle after the first push, then pc=0x4, in order; d_pc_next_o=0x4 and then 0x8.
REQ-038 DEPTH=2, d_ready_i=0, three consecutive pushes -> count_o=2, f_ready_o=0, the third push is dropped, and the head stays pc=0x0.
REQ-039 Full buffer, f_valid_i=1 and d_ready_i=1 in the same cycle -> only the pop occurs, count_o=1, and f_ready_o=1 in the next cycle.
REQ-040 Two entries buffered, flush_i=1 together with f_valid_i=1 -> count_o=0 and d_valid_o=0 in the next cycle, d_instr_o=0x00000013, and the new entry is absent.
REQ-041 DEPTH=4, steady push/pop for 10 entries -> pointers wrap and the output PC sequence is strictly +4 with no loss or duplication.
REQ-042 arstn_i pulsed low between clock edges with 3 entries held -> count_o=0 and d_valid_o=0 without waiting for a clock edge.

Source files
------------

// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared RISC-V widths, NOP encoding and fetch packet type
package rv_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned ILEN = 32;

   localparam logic [ILEN-1:0] RV_NOP = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc_next;
      logic [ILEN-1:0] instr;
   } fetch_pkt_t;

endpackage

// File: rtl/rv_fetch_buffer.sv
// rtl/rv_fetch_buffer.sv - circular FIFO decoupling instruction fetch from decode
module rv_fetch_buffer
   import rv_pkg::*;
#(
   parameter int unsigned DEPTH = 2
)(
   input  logic                       clk_i,
   input  logic                       arstn_i,
   input  logic                       flush_i,
   input  logic                       f_valid_i,
   input  logic [XLEN-1:0]            f_pc_i,
   input  logic [XLEN-1:0]            f_pc_next_i,
   input  logic [ILEN-1:0]            f_instr_i,
   output logic                       f_ready_o,
   output logic                       d_valid_o,
   output logic [XLEN-1:0]            d_pc_o,
   output logic [XLEN-1:0]            d_pc_next_o,
   output logic [ILEN-1:0]            d_instr_o,
   input  logic                       d_ready_i,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   fetch_pkt_t    r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   logic       w_full;
   logic       w_empty;
   logic       w_push;
   logic       w_pop;
   fetch_pkt_t w_head;

   // Readiness depends only on occupancy so decode cannot form a loop back into fetch.
   assign w_full  = (r_count == FULL_CNT);
   assign w_empty = (r_count == '0);
   assign w_push  = f_valid_i & ~w_full & ~flush_i;
   assign w_pop   = ~w_empty & d_ready_i & ~flush_i;

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   // Entries are left unreset; the empty-mask on the outputs hides stale contents.
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= '{pc: f_pc_i, pc_next: f_pc_next_i, instr: f_instr_i};
      end
   end

   assign w_head      = r_mem[r_rd_ptr];
   assign f_ready_o   = ~w_full;
   assign d_valid_o   = ~w_empty;
   assign d_pc_o      = w_empty ? '0     : w_head.pc;
   assign d_pc_next_o = w_empty ? '0     : w_head.pc_next;
   assign d_instr_o   = w_empty ? RV_NOP : w_head.instr;
   assign count_o     = r_count;

   a_no_push_full: assert property (@(posedge clk_i) disable iff (!arstn_i)
      !(w_push && w_full));
   a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!arstn_i)
      !(w_pop && w_empty));

endmodule

// File: tb/tb_rv_fetch_buffer.sv
// tb/tb_rv_fetch_buffer.sv - directed vector bench for rv_fetch_buffer
module tb_rv_fetch_buffer;
   import rv_pkg::*;

   localparam logic [31:0] I1 = 32'h0050_0093;
   localparam logic [31:0] I2 = 32'h00A0_0113;
   localparam logic [31:0] I3 = 32'h00F0_0193;
   localparam logic [31:0] I4 = 32'h0140_0213;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic clk_i = 1'b0;
   logic arstn_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // DEPTH=2 instance
   logic            flush, fv, fr, dv, dr;
   logic [XLEN-1:0] pc, pcn, dpc, dpcn;
   logic [ILEN-1:0] ins, dins;
   logic [1:0]      cnt;

   // DEPTH=4 instance
   logic            flush4, fv4, fr4, dv4, dr4;
   logic [XLEN-1:0] pc4, pcn4, dpc4, dpcn4;
   logic [ILEN-1:0] ins4, dins4;
   logic [2:0]      cnt4;

   rv_fetch_buffer #(.DEPTH(2)) dut (
      .clk_i(clk_i), .arstn_i(arstn_i), .flush_i(flush),
      .f_valid_i(fv), .f_pc_i(pc), .f_pc_next_i(pcn), .f_instr_i(ins),
      .f_ready_o(fr), .d_valid_o(dv), .d_pc_o(dpc), .d_pc_next_o(dpcn),
      .d_instr_o(dins), .d_ready_i(dr), .count_o(cnt)
   );

   rv_fetch_buffer #(.DEPTH(4)) dut4 (
      .clk_i(clk_i), .arstn_i(arstn_i), .flush_i(flush4),
      .f_valid_i(fv4), .f_pc_i(pc4), .f_pc_next_i(pcn4), .f_instr_i(ins4),
      .f_ready_o(fr4), .d_valid_o(dv4), .d_pc_o(dpc4), .d_pc_next_o(dpcn4),
      .d_instr_o(dins4), .d_ready_i(dr4), .count_o(cnt4)
   );

   typedef struct {
      logic        flush;
      logic        fv;
      logic [31:0] pc;
      logic [31:0] ins;
      logic        dr;
      logic        dv;
      logic [31:0] dpc;
      logic [31:0] dins;
      logic        fr;
      int          cnt;
   } vec_t;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic fl, input logic f_v, input logic [31:0] p,
                               input logic [31:0] i, input logic d_r, input logic d_v,
                               input logic [31:0] d_p, input logic [31:0] d_i,
                               input logic f_r, input int c);
      vec_t v;
      v.flush = fl; v.fv = f_v; v.pc = p; v.ins = i; v.dr = d_r;
      v.dv = d_v; v.dpc = d_p; v.dins = d_i; v.fr = f_r; v.cnt = c;
      return v;
   endfunction

   task automatic step4(input logic f_v, input logic [31:0] p, input logic d_r);
      fv4 = f_v; pc4 = p; pcn4 = p + 32'd4; ins4 = {p[24:0], 7'h13}; dr4 = d_r;
      @(posedge clk_i); #1;
   endtask

   vec_t vecs[12];
   logic prev_fr;
   int   k, popped;
   logic rdy;

   initial begin
      flush = 1'b0; fv = 1'b0; pc = '0; pcn = '0; ins = '0; dr = 1'b0;
      flush4 = 1'b0; fv4 = 1'b0; pc4 = '0; pcn4 = '0; ins4 = '0; dr4 = 1'b0;

      // flush, fv, pc, instr, dr  ->  dv, d_pc, d_instr, f_ready, count
      vecs[0]  = mk(1'b0, 1'b1, 32'h0,  I1, 1'b1, 1'b1, 32'h0,  I1,  1'b1, 1);
      vecs[1]  = mk(1'b0, 1'b1, 32'h4,  I2, 1'b1, 1'b1, 32'h4,  I2,  1'b1, 1);
      vecs[2]  = mk(1'b0, 1'b0, 32'h0,  I1, 1'b1, 1'b0, 32'h0,  NOP, 1'b1, 0);
      vecs[3]  = mk(1'b0, 1'b1, 32'h0,  I1, 1'b0, 1'b1, 32'h0,  I1,  1'b1, 1);
      vecs[4]  = mk(1'b0, 1'b1, 32'h4,  I2, 1'b0, 1'b1, 32'h0,  I1,  1'b0, 2);
      vecs[5]  = mk(1'b0, 1'b1, 32'h8,  I3, 1'b0, 1'b1, 32'h0,  I1,  1'b0, 2);
      vecs[6]  = mk(1'b0, 1'b1, 32'h8,  I3, 1'b1, 1'b1, 32'h4,  I2,  1'b1, 1);
      vecs[7]  = mk(1'b0, 1'b1, 32'h8,  I3, 1'b0, 1'b1, 32'h4,  I2,  1'b0, 2);
      vecs[8]  = mk(1'b1, 1'b1, 32'hC,  I4, 1'b1, 1'b0, 32'h0,  NOP, 1'b1, 0);
      vecs[9]  = mk(1'b0, 1'b0, 32'hC,  I4, 1'b0, 1'b0, 32'h0,  NOP, 1'b1, 0);
      vecs[10] = mk(1'b0, 1'b1, 32'h10, I4, 1'b0, 1'b1, 32'h10, I4,  1'b1, 1);
      vecs[11] = mk(1'b0, 1'b0, 32'h0,  I1, 1'b1, 1'b0, 32'h0,  NOP, 1'b1, 0);

      #12;
      chk("rst_count", {30'b0, cnt}, 32'd0);
      chk("rst_dvalid", {31'b0, dv}, 32'd0);
      chk("rst_fready", {31'b0, fr}, 32'd1);
      chk("rst_dpc", dpc, 32'h0);
      chk("rst_dpcnext", dpcn, 32'h0);
      chk("rst_dinstr", dins, NOP);
      arstn_i = 1'b1;

      prev_fr = 1'b1;
      for (int i = 0; i < 12; i++) begin
         flush = vecs[i].flush; fv = vecs[i].fv; pc = vecs[i].pc;
         pcn = vecs[i].pc + 32'd4; ins = vecs[i].ins; dr = vecs[i].dr;
         #1;
         chk($sformatf("v%0d_fready_pre", i), {31'b0, fr}, {31'b0, prev_fr});
         @(posedge clk_i); #1;
         chk($sformatf("v%0d_dvalid", i), {31'b0, dv}, {31'b0, vecs[i].dv});
         chk($sformatf("v%0d_dpc", i), dpc, vecs[i].dpc);
         chk($sformatf("v%0d_dpcnext", i), dpcn, vecs[i].dv ? vecs[i].dpc + 32'd4 : 32'h0);
         chk($sformatf("v%0d_dinstr", i), dins, vecs[i].dins);
         chk($sformatf("v%0d_fready", i), {31'b0, fr}, {31'b0, vecs[i].fr});
         chk($sformatf("v%0d_count", i), {30'b0, cnt}, 32'(vecs[i].cnt));
         prev_fr = vecs[i].fr;
      end
      flush = 1'b0; fv = 1'b0; dr = 1'b0;

      // Steady streaming through DEPTH=4 wraps both pointers twice.
      k = 0; popped = 0;
      for (int c = 0; c < 16; c++) begin
         rdy = fr4;
         step4(k < 10, 32'h100 + 32'(4 * k), 1'b1);
         if (fv4 && rdy) k++;
         if (dv4) begin
            chk($sformatf("stream_pc%0d", popped), dpc4, 32'h100 + 32'(4 * popped));
            chk($sformatf("stream_pcn%0d", popped), dpcn4, 32'h104 + 32'(4 * popped));
            popped++;
         end
      end
      fv4 = 1'b0;
      chk("stream_pushed", 32'(k), 32'd10);
      chk("stream_popped", 32'(popped), 32'd10);
      chk("stream_count_end", {29'b0, cnt4}, 32'd0);

      // Asynchronous reset with three entries held.
      step4(1'b1, 32'h200, 1'b0);
      step4(1'b1, 32'h204, 1'b0);
      step4(1'b1, 32'h208, 1'b0);
      fv4 = 1'b0;
      chk("held_count", {29'b0, cnt4}, 32'd3);
      chk("held_head", dpc4, 32'h200);
      #2;
      arstn_i = 1'b0;
      #1;
      chk("arst_count", {29'b0, cnt4}, 32'd0);
      chk("arst_dvalid", {31'b0, dv4}, 32'd0);
      chk("arst_dinstr", dins4, NOP);
      chk("arst_fready", {31'b0, fr4}, 32'd1);
      #1;
      arstn_i = 1'b1;
      step4(1'b1, 32'h300, 1'b0);
      fv4 = 1'b0;
      chk("post_rst_count", {29'b0, cnt4}, 32'd1);
      chk("post_rst_head", dpc4, 32'h300);
      chk("post_rst_instr", dins4, {25'h300, 7'h13});
      step4(1'b0, 32'h0, 1'b1);
      chk("post_rst_drain", {29'b0, cnt4}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
